mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single-port unified memory between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write).
- Sits between the pipeline's IF/MEM stages and the memory array.
- Grants one requester per cycle and routes the 1-cycle-latency read response back to that requester.
- Data side has priority; a streak limiter prevents fetch starvation.

Parameters:
- ADDR_W, 16: word-address width of the memory port (memory depth 2^ADDR_W words).
- D_STREAK_MAX, 4: maximum consecutive D grants while i_req is pending before I is forced (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch byte address (word-aligned)
- i_gnt  out  1  fetch granted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  32  fetched word
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  data response (load data or store ack)
- d_rdata  out  32  load word
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_be  out  4  memory byte enables
- m_addr  out  ADDR_W  word address = granted addr[ADDR_W+1:2]
- m_wdata  out  32  write data
- m_rdata  in  32  memory read data, valid one cycle after m_en & !m_we

Behaviour:
- Grant (combinational, same cycle as request):
  - Only I requests: I is granted.
  - Only D requests: D is granted.
  - Both request, state D_PRIO: D is granted.
  - Both request, state I_FORCE: I is granted.
  - No request: no grant; m_en=0; m_we=0; m_be=0.
- i_gnt and d_gnt are never both high.
- Memory mux:
  - m_en = i_gnt | d_gnt.
  - m_we = d_gnt & d_we.
  - m_be = (d_gnt & d_we) ? d_be : 4'b0000.
  - m_addr and m_wdata follow the granted requester; m_wdata = 0 on I grant.
- A requester holds its req, addr and data stable until it sees its gnt. Deasserting req before grant is legal; the request is dropped.
- Response:
  - Registered owner/valid flags.
  - I grant in cycle N: i_rvalid=1 in N+1, with i_rdata = m_rdata.
  - D load grant in N: d_rvalid=1 in N+1, with d_rdata = m_rdata.
  - D store grant in N: d_rvalid=1 in N+1, with d_rdata = 0.
  - A non-granted side's rdata is 0. rvalid is a single-cycle pulse per grant.
  - Back-to-back grants give back-to-back rvalids; no bubbles are required.
- Starvation FSM, with a 4-bit streak counter:
  - D_PRIO: each cycle with d_gnt & i_req increments the streak. When the streak reaches D_STREAK_MAX, move to I_FORCE.
  - D_PRIO: any i_gnt, or a cycle with !i_req, clears the streak.
  - I_FORCE: the next cycle with i_req grants I, clears the streak and returns to D_PRIO.
  - I_FORCE: if i_req drops, return to D_PRIO with streak cleared.
- Reset (rst low, asynchronous):
  - state = D_PRIO, streak = 0, i_rvalid = d_rvalid = 0, rdata outputs = 0.
  - Grants and m_en are forced to 0 while rst is low.
- Reset asserted mid-access: the pending response is discarded; no rvalid after release.
- First grant possible in the first cycle with rst high.
- Address bits [1:0] and the bits above ADDR_W+1 are ignored; alignment is the requester's responsibility.

Test Plan:
1. Reset released, i_req=1, i_addr=0x44, memory word 17 = 0x00100193 -> i_gnt same cycle, m_addr=17, i_rvalid=1 next cycle with i_rdata=0x00100193; d_rvalid stays 0.
2. d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF -> m_we=1, m_be=0011, m_addr=0x40, d_rvalid=1 next cycle with d_rdata=0. A following load from 0x100 (prior contents 0) returns 0x0000BEEF.
3. i_req and d_req held high continuously, D_STREAK_MAX=4 -> grant pattern D,D,D,D,I repeating; i_gnt never low for more than 4 consecutive cycles.
4. Alternating I and D grants on consecutive cycles -> rvalids alternate i/d with no bubble, each paired with its own address's data.
5. rst pulled low one cycle after a D load grant -> no d_rvalid after release; state D_PRIO, streak 0. The first post-reset request is granted immediately.
6. i_req withdrawn in I_FORCE, d_req held -> D granted that cycle, state returns to D_PRIO, streak restarts at 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch requester (I), the load/store requester (D),
// the arbiter, and the single-port memory array.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  // Fetch requester
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  // Memory port
  logic              m_en;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  // Arbiter view
  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_be, m_addr, m_wdata,
    input  m_rdata
  );

  // Requesters plus memory array view
  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_be, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data side has priority, a streak limiter forces a
// fetch grant after D_STREAK_MAX consecutive data wins; 1-cycle read return.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int D_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {
    D_PRIO  = 1'b0,
    I_FORCE = 1'b1
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        i_gnt, d_gnt;
  logic        i_rvalid_q, d_rvalid_q, d_store_q;
  logic [31:0] sel_addr;

  // Grant decision; held off entirely while reset is asserted.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      i_gnt = bus.i_req & (~bus.d_req | (state_q == I_FORCE));
      d_gnt = bus.d_req & ~i_gnt;
    end
  end

  always_comb begin
    sel_addr = '0;
    if (d_gnt) begin
      sel_addr = bus.d_addr;
    end else if (i_gnt) begin
      sel_addr = bus.i_addr;
    end
  end

  assign bus.i_gnt   = i_gnt;
  assign bus.d_gnt   = d_gnt;
  assign bus.m_en    = i_gnt | d_gnt;
  assign bus.m_we    = d_gnt & bus.d_we;
  assign bus.m_be    = (d_gnt & bus.d_we) ? bus.d_be : 4'b0000;
  assign bus.m_addr  = sel_addr[ADDR_W+1:2];
  assign bus.m_wdata = d_gnt ? bus.d_wdata : 32'h0;

  // Starvation limiter. I_FORCE always lasts one cycle: either I is granted or
  // i_req has dropped, and both cases return to D_PRIO with a cleared streak.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      D_PRIO: begin
        if (!bus.i_req || i_gnt) begin
          streak_d = 4'd0;
        end else if (d_gnt) begin
          streak_d = streak_q + 4'd1;
          if (streak_d == STREAK_MAX) begin
            state_d = I_FORCE;
          end
        end
      end
      I_FORCE: begin
        streak_d = 4'd0;
        state_d  = D_PRIO;
      end
      default: begin
        streak_d = 4'd0;
        state_d  = D_PRIO;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= D_PRIO;
      streak_q   <= 4'd0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_store_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      i_rvalid_q <= i_gnt;
      d_rvalid_q <= d_gnt;
      d_store_q  <= d_gnt & bus.d_we;
    end
  end

  // Response routing: memory data goes only to the owner of last cycle's grant.
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rvalid_q ? bus.m_rdata : 32'h0;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = (d_rvalid_q & ~d_store_q) ? bus.m_rdata : 32'h0;

  // Byte-offset and high address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.i_addr[1:0], bus.i_addr[31:ADDR_W+2],
                              bus.d_addr[1:0], bus.d_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 16;
  localparam int D_STREAK_MAX = 4;
  localparam int DEPTH        = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .D_STREAK_MAX(D_STREAK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory array fixture driving m_rdata
  bit [31:0] fx_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.m_en === 1'b1) begin
      if (bus.m_we === 1'b1) begin
        for (int b = 0; b < 4; b++)
          if (bus.m_be[b]) fx_mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end else begin
        bus.m_rdata <= fx_mem[bus.m_addr];
      end
    end
  end

  // Reference model: memory image, count of consecutive D wins while I waits,
  // and the response owed in the next cycle.
  typedef struct packed {
    bit        valid;
    bit        is_i;
    bit        is_store;
    bit [31:0] data;
  } resp_t;

  bit [31:0]         ref_mem [0:DEPTH-1];
  int                run;
  resp_t             pend;
  bit                exp_i_gnt, exp_d_gnt, exp_m_en, exp_m_we;
  bit [3:0]          exp_m_be;
  logic [ADDR_W-1:0] exp_m_addr;
  bit [31:0]         exp_m_wdata;
  bit                exp_i_rvalid, exp_d_rvalid;
  bit [31:0]         exp_i_rdata, exp_d_rdata;

  function automatic int unsigned word_of(logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic void predict();
    exp_i_gnt = 0; exp_d_gnt = 0; exp_m_en = 0; exp_m_we = 0; exp_m_be = 0;
    exp_m_addr = '0; exp_m_wdata = 0;
    exp_i_rvalid = 0; exp_d_rvalid = 0; exp_i_rdata = 0; exp_d_rdata = 0;
    if (rst) begin
      exp_i_gnt   = bus.i_req && (!bus.d_req || run >= D_STREAK_MAX);
      exp_d_gnt   = bus.d_req && !exp_i_gnt;
      exp_m_en    = exp_i_gnt || exp_d_gnt;
      exp_m_we    = exp_d_gnt && bus.d_we;
      exp_m_be    = exp_m_we ? bus.d_be : 4'b0000;
      if (exp_d_gnt) begin
        exp_m_addr  = ADDR_W'(word_of(bus.d_addr));
        exp_m_wdata = bus.d_wdata;
      end else if (exp_i_gnt) begin
        exp_m_addr  = ADDR_W'(word_of(bus.i_addr));
      end
      exp_i_rvalid = pend.valid && pend.is_i;
      exp_d_rvalid = pend.valid && !pend.is_i;
      exp_i_rdata  = exp_i_rvalid ? pend.data : 32'h0;
      exp_d_rdata  = (exp_d_rvalid && !pend.is_store) ? pend.data : 32'h0;
    end
  endfunction

  function automatic void commit();
    int unsigned w;
    if (!rst) begin
      run  = 0;
      pend = '0;
      return;
    end
    pend = '0;
    if (exp_i_gnt) begin
      w = word_of(bus.i_addr);
      pend.valid = 1; pend.is_i = 1; pend.data = ref_mem[w];
    end else if (exp_d_gnt) begin
      w = word_of(bus.d_addr);
      pend.valid = 1;
      if (bus.d_we) begin
        pend.is_store = 1;
        for (int b = 0; b < 4; b++)
          if (bus.d_be[b]) ref_mem[w][8*b +: 8] = bus.d_wdata[8*b +: 8];
      end else begin
        pend.data = ref_mem[w];
      end
    end
    if (!bus.i_req || exp_i_gnt) run = 0;
    else run++;
  endfunction

  task automatic set_i(input bit req, input logic [31:0] addr);
    bus.i_req  = req;
    bus.i_addr = addr;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  // Cycle phases: inputs change at posedge+1, outputs sampled at posedge+4.
  task automatic settle();
    #3;
    predict();
  endtask

  task automatic advance();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_i(1, 32'h44);
    set_d(1, 0, 4'h0, 32'h100, 32'h0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got=%b exp=0", bus.i_gnt); end
      checks++; if (bus.d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got=%b exp=0", bus.d_gnt); end
      checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en got=%b exp=0", bus.m_en); end
      checks++; if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", bus.i_rvalid, bus.d_rvalid); end
      checks++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.i_rdata, bus.d_rdata); end
      advance();
    end
  endtask

  task automatic test_fetch();
    rst = 1'b1;
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    set_i(1, 32'h44);
    settle();
    checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%b exp=1", bus.i_gnt); end
    checks++; if (bus.m_addr !== 16'd17) begin errors++; $display("FAIL fetch_m_addr got=%0d exp=17", bus.m_addr); end
    checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL fetch_m_we got=%b exp=0", bus.m_we); end
    advance();
    set_i(0, 32'h0);
    settle();
    checks++; if (bus.i_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid got=%b exp=1", bus.i_rvalid); end
    checks++; if (bus.i_rdata !== 32'h0010_0193) begin errors++; $display("FAIL fetch_rdata got=%h exp=00100193", bus.i_rdata); end
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got=%b exp=0", bus.d_rvalid); end
    advance();
  endtask

  task automatic test_store_load();
    set_d(1, 1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    settle();
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got=%b exp=1", bus.d_gnt); end
    checks++; if ({bus.m_we, bus.m_be} !== 5'b1_0011) begin errors++; $display("FAIL store_we_be got=%b/%b exp=1/0011", bus.m_we, bus.m_be); end
    checks++; if (bus.m_addr !== 16'h0040) begin errors++; $display("FAIL store_m_addr got=%h exp=0040", bus.m_addr); end
    checks++; if (bus.m_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_m_wdata got=%h exp=deadbeef", bus.m_wdata); end
    advance();
    set_d(1, 0, 4'b0000, 32'h100, 32'h0);
    settle();
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL store_ack got=%b exp=1", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL store_ack_data got=%h exp=0", bus.d_rdata); end
    checks++; if ({bus.m_we, bus.m_be} !== 5'b0_0000) begin errors++; $display("FAIL load_we_be got=%b/%b exp=0/0000", bus.m_we, bus.m_be); end
    advance();
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    settle();
    checks++; if (bus.d_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid got=%b exp=1", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL load_rdata got=%h exp=0000beef", bus.d_rdata); end
    advance();
  endtask

  // Both sides requesting from a cleared streak: D x D_STREAK_MAX, then I.
  task automatic check_pattern(input string tag, input int n);
    bit want_i;
    for (int k = 0; k < n; k++) begin
      want_i = (k % (D_STREAK_MAX + 1)) == D_STREAK_MAX;
      settle();
      checks++;
      if ({bus.i_gnt, bus.d_gnt} !== {want_i, !want_i}) begin
        errors++;
        $display("FAIL %s_grant k=%0d got i/d=%b%b exp=%b%b", tag, k, bus.i_gnt, bus.d_gnt, want_i, !want_i);
      end
      advance();
    end
  endtask

  task automatic test_streak();
    set_i(1, 32'h0000_0FA0);
    set_d(1, 0, 4'h0, 32'h0000_0FA4, 32'h0);
    check_pattern("streak", 15);
    set_i(0, 32'h0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    settle();
    advance();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        set_i(0, 32'h0); set_d(0, 0, 4'h0, 32'h0, 32'h0);
      end else if (k % 2 == 0) begin
        set_i(1, (32'd1000 + 32'(k)) << 2); set_d(0, 0, 4'h0, 32'h0, 32'h0);
      end else begin
        set_i(0, 32'h0); set_d(1, 0, 4'h0, (32'd1000 + 32'(k)) << 2, 32'h0);
      end
      settle();
      if (k > 0) begin
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== {((k-1) % 2 == 0), ((k-1) % 2 == 1)}) begin
          errors++; $display("FAIL b2b_rvalid k=%0d got i/d=%b%b", k, bus.i_rvalid, bus.d_rvalid);
        end
        checks++;
        if (bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
          errors++; $display("FAIL b2b_rdata k=%0d got %h/%h exp %h/%h", k, bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    set_i(1, 32'h0000_0FA0);
    set_d(1, 0, 4'h0, 32'h0000_0FA4, 32'h0);
    for (int k = 0; k < 3; k++) begin
      settle();
      advance();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_d_rvalid k=%0d got=%b exp=0", k, bus.d_rvalid); end
      checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL rstmid_m_en k=%0d got=%b exp=0", k, bus.m_en); end
      advance();
    end
    rst = 1'b1;
    settle();
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_release_rvalid got=%b exp=0", bus.d_rvalid); end
    checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_first_gnt got=%b exp=1", bus.d_gnt); end
    #0;
    // Streak must restart from zero: D x D_STREAK_MAX then I, counting this cycle.
    check_pattern("rstmid", D_STREAK_MAX + 1);
  endtask

  task automatic test_force_drop();
    check_pattern("drop_pre", D_STREAK_MAX);
    set_i(0, 32'h0);
    settle();
    checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin errors++; $display("FAIL drop_grant got i/d=%b%b exp=01", bus.i_gnt, bus.d_gnt); end
    advance();
    set_i(1, 32'h0000_0FA0);
    check_pattern("drop_post", D_STREAK_MAX + 1);
    set_i(0, 32'h0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);
    settle();
    advance();
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFC_0003) | ((32'd1000 + 32'($urandom_range(0, 31))) << 2);
  endfunction

  task automatic test_random();
    bit i_pend = 0;
    bit d_pend = 0;
    for (int c = 0; c < 600; c++) begin
      if (rst == 1'b0) rst = 1'b1;
      else if ($urandom_range(0, 59) == 0) rst = 1'b0;
      if (!i_pend || $urandom_range(0, 9) == 0) begin
        i_pend = $urandom_range(0, 2) != 0;
        set_i(i_pend, rand_addr());
      end
      if (!d_pend || $urandom_range(0, 9) == 0) begin
        d_pend = $urandom_range(0, 2) != 0;
        set_d(d_pend, 1'($urandom), 4'($urandom), rand_addr(), $urandom);
      end
      settle();
      checks++; if ({bus.i_gnt, bus.d_gnt} !== {exp_i_gnt, exp_d_gnt}) begin errors++; $display("FAIL rand_gnt c=%0d got i/d=%b%b exp=%b%b", c, bus.i_gnt, bus.d_gnt, exp_i_gnt, exp_d_gnt); end
      checks++; if ({bus.m_en, bus.m_we, bus.m_be} !== {exp_m_en, exp_m_we, exp_m_be}) begin errors++; $display("FAIL rand_mctl c=%0d got en/we/be=%b/%b/%b exp=%b/%b/%b", c, bus.m_en, bus.m_we, bus.m_be, exp_m_en, exp_m_we, exp_m_be); end
      if (exp_m_en) begin
        checks++; if (bus.m_addr !== exp_m_addr) begin errors++; $display("FAIL rand_m_addr c=%0d got=%h exp=%h", c, bus.m_addr, exp_m_addr); end
        checks++; if (bus.m_wdata !== exp_m_wdata) begin errors++; $display("FAIL rand_m_wdata c=%0d got=%h exp=%h", c, bus.m_wdata, exp_m_wdata); end
      end
      checks++; if ({bus.i_rvalid, bus.d_rvalid} !== {exp_i_rvalid, exp_d_rvalid}) begin errors++; $display("FAIL rand_rvalid c=%0d got i/d=%b%b exp=%b%b", c, bus.i_rvalid, bus.d_rvalid, exp_i_rvalid, exp_d_rvalid); end
      checks++; if (bus.i_rdata !== exp_i_rdata) begin errors++; $display("FAIL rand_i_rdata c=%0d got=%h exp=%h", c, bus.i_rdata, exp_i_rdata); end
      checks++; if (bus.d_rdata !== exp_d_rdata) begin errors++; $display("FAIL rand_d_rdata c=%0d got=%h exp=%h", c, bus.d_rdata, exp_d_rdata); end
      if (exp_i_gnt) i_pend = 0;
      if (exp_d_gnt) d_pend = 0;
      advance();
    end
    rst = 1'b1;
  endtask

  initial begin
    bit [31:0] v;
    run  = 0;
    pend = '0;
    for (int i = 1000; i < 1256; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      fx_mem[i] <= v;
    end
    ref_mem[17] = 32'h0010_0193;
    fx_mem[17] <= 32'h0010_0193;
    set_i(0, 32'h0);
    set_d(0, 0, 4'h0, 32'h0, 32'h0);

    test_reset();
    test_fetch();
    test_store_load();
    test_streak();
    test_back_to_back();
    test_reset_mid();
    test_force_drop();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
